// File: rtl/micro_alpha_veryl_shift_sequencer.sv
// micro_alpha_veryl_shift_sequencer
//
// Multi-cycle controller in front of the single-bit shifter. It takes a
// request for N shift steps and drives the shifter once per cycle. The
// shifter's out/cout are fed back into an accumulator until the count runs
// out. The final word and carry are then presented with a one-cycle done
// pulse. Non-shift shifter operations (EXTENSION, SWAP, NOP) make exactly
// one pass through the shifter.
//
// The operation encoding matches shifter_operation_t of the shifter:
//   0 NOP, 1 LEFT_LOGICALLY, 2 RIGHT_LOGICALLY, 3 LEFT_ARITHMETICALLY,
//   4 RIGHT_ARITHMETICALLY, 5 EXTENSION, 6 SWAP.

module micro_alpha_veryl_shift_sequencer #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   ready,
    output logic                   busy,
    input  logic [2:0]             operation,
    input  logic [WIDTH-1:0]       data_in,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic                   fill,
    output logic                   done,
    output logic [WIDTH-1:0]       result,
    output logic                   carry,
    output logic [2:0]             sh_operation,
    output logic [WIDTH-1:0]       sh_in,
    output logic                   sh_cin,
    input  logic [WIDTH-1:0]       sh_out,
    input  logic                   sh_cout
);

    // Shifter operation codes
    localparam logic [2:0] OP_NOP                  = 3'd0;
    localparam logic [2:0] OP_LEFT_LOGICALLY       = 3'd1;
    localparam logic [2:0] OP_RIGHT_LOGICALLY      = 3'd2;
    localparam logic [2:0] OP_LEFT_ARITHMETICALLY  = 3'd3;
    localparam logic [2:0] OP_RIGHT_ARITHMETICALLY = 3'd4;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    // Registered state
    logic [1:0]             state_q,     state_d;
    logic [WIDTH-1:0]       acc_q,       acc_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0]       result_q,    result_d;
    logic                   carry_q,     carry_d;
    logic [2:0]             op_q,        op_d;
    logic                   fill_q,      fill_d;

    // True for the four real shift operations, which honour the count
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_LEFT_LOGICALLY)      ||
               (op == OP_RIGHT_LOGICALLY)     ||
               (op == OP_LEFT_ARITHMETICALLY) ||
               (op == OP_RIGHT_ARITHMETICALLY);
    endfunction

    // Next-state logic: request acceptance, per-step accumulation, completion
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        result_d    = result_q;
        carry_d     = carry_q;
        op_d        = op_q;
        fill_d      = fill_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d  = data_in;
                    op_d   = operation;
                    fill_d = fill;
                    if (is_shift_op(operation)) begin
                        if (count != '0) begin
                            remaining_d = count;
                            state_d     = ST_SHIFT;
                        end else begin
                            // Zero-length shift: no shifter pass, publish the
                            // operand directly with a clear carry.
                            remaining_d = '0;
                            result_d    = data_in;
                            carry_d     = 1'b0;
                            state_d     = ST_DONE;
                        end
                    end else begin
                        remaining_d = CNT_ONE;
                        state_d     = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                acc_d = sh_out;
                if (remaining_q != '0) begin
                    remaining_d = remaining_q - CNT_ONE;
                end
                // The last step (or an impossible zero count) completes the
                // request; the counter saturates at zero instead of wrapping.
                if (remaining_q <= CNT_ONE) begin
                    result_d = sh_out;
                    carry_d  = sh_cout;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            op_q        <= OP_NOP;
            fill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            op_q        <= op_d;
            fill_q      <= fill_d;
        end
    end

    // Status outputs and shifter drive; the shifter is held quiescent
    // whenever no step is in progress.
    always_comb begin
        ready        = (state_q == ST_IDLE);
        busy         = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        done         = (state_q == ST_DONE);
        result       = result_q;
        carry        = carry_q;
        sh_operation = OP_NOP;
        sh_in        = '0;
        sh_cin       = 1'b0;
        if (state_q == ST_SHIFT) begin
            sh_operation = op_q;
            sh_in        = acc_q;
            sh_cin       = fill_q;
        end
    end

endmodule

// File: tb/tb_micro_alpha_veryl_shift_sequencer.sv
// Testbench for micro_alpha_veryl_shift_sequencer with a behavioural
// single-bit shifter closing the loop on sh_* ports.

module tb_micro_alpha_veryl_shift_sequencer;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_LEFT_L  = 3'd1;
    localparam logic [2:0] OP_RIGHT_L = 3'd2;
    localparam logic [2:0] OP_LEFT_A  = 3'd3;
    localparam logic [2:0] OP_RIGHT_A = 3'd4;
    localparam logic [2:0] OP_EXT     = 3'd5;
    localparam logic [2:0] OP_SWAP    = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic        busy;
    logic [2:0]  operation;
    logic [15:0] data_in;
    logic [3:0]  count;
    logic        fill;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic [2:0]  sh_operation;
    logic [15:0] sh_in;
    logic        sh_cin;
    logic [15:0] sh_out;
    logic        sh_cout;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [15:0] sh_log [0:39];
    int          glitch_k;
    bit          op_moved;

    always #5 clk = ~clk;

    micro_alpha_veryl_shift_sequencer #(.WIDTH(16), .COUNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .busy(busy),
        .operation(operation), .data_in(data_in), .count(count), .fill(fill),
        .done(done), .result(result), .carry(carry),
        .sh_operation(sh_operation), .sh_in(sh_in), .sh_cin(sh_cin),
        .sh_out(sh_out), .sh_cout(sh_cout)
    );

    // Behavioural single-bit shifter
    always_comb begin
        sh_out  = sh_in;
        sh_cout = 1'b0;
        case (sh_operation)
            OP_LEFT_L:  begin sh_out = {sh_in[14:0], sh_cin};  sh_cout = sh_in[15]; end
            OP_LEFT_A:  begin sh_out = {sh_in[14:0], 1'b0};    sh_cout = sh_in[15]; end
            OP_RIGHT_L: begin sh_out = {sh_cin, sh_in[15:1]};  sh_cout = sh_in[0];  end
            OP_RIGHT_A: begin sh_out = {sh_in[15], sh_in[15:1]}; sh_cout = sh_in[0]; end
            OP_EXT:     begin sh_out = {{8{sh_in[7]}}, sh_in[7:0]}; sh_cout = sh_in[7]; end
            OP_SWAP:    begin sh_out = {sh_in[7:0], sh_in[15:8]}; sh_cout = 1'b0; end
            default:    begin sh_out = sh_in; sh_cout = 1'b0; end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one request, wait (bounded) for done, check latency/result/carry
    task automatic run_req(input string tag, input logic [2:0] op, input logic [15:0] din,
                           input logic [3:0] cnt, input logic fl, input int exp_lat,
                           input logic [15:0] exp_res, input logic exp_c);
        int lat;
        int busy_cycles;
        lat = 0;
        busy_cycles = 0;
        op_moved = 1'b0;
        @(negedge clk);
        operation = op; data_in = din; count = cnt; fill = fl; start = 1'b1;
        @(posedge clk);
        #1;
        // Perturb inputs after acceptance; they must not matter any more
        start = 1'b0; operation = OP_LEFT_A; data_in = 16'h5A5A; count = 4'hF; fill = ~fl;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            sh_log[k-1] = sh_in;
            if (sh_operation != OP_NOP) op_moved = 1'b1;
            if (busy) busy_cycles++;
            if (done) begin
                lat = k;
                break;
            end
            start = (k == glitch_k);
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_carry"}, carry, exp_c);
        check_eq({tag, "_busy_cycles"}, busy_cycles, exp_lat);
        @(negedge clk);
        check_eq({tag, "_done_pulse_one_cycle"}, done, 0);
        check_eq({tag, "_ready_after"}, ready, 1);
        check_eq({tag, "_result_held"}, result, exp_res);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; operation = OP_NOP; data_in = '0; count = '0; fill = 1'b0;
        glitch_k = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_carry", carry, 0);
        check_eq("rst_sh_op", sh_operation, OP_NOP);
        check_eq("rst_sh_in", sh_in, 0);
        rst = 1'b1;

        run_req("ll1", OP_LEFT_L, 16'hA5A5, 4'd1, 1'b0, 2, 16'h4B4A, 1'b1);

        run_req("rl3", OP_RIGHT_L, 16'hA5A5, 4'd3, 1'b1, 4, 16'hF4B4, 1'b1);
        check_eq("rl3_acc0", sh_log[0], 16'hA5A5);
        check_eq("rl3_acc1", sh_log[1], 16'hD2D2);
        check_eq("rl3_acc2", sh_log[2], 16'hE969);

        glitch_k = 5;
        run_req("ra15", OP_RIGHT_A, 16'h8000, 4'd15, 1'b0, 16, 16'hFFFF, 1'b0);
        glitch_k = 0;

        run_req("ll0", OP_LEFT_L, 16'h1234, 4'd0, 1'b0, 1, 16'h1234, 1'b0);
        check_eq("ll0_sh_op_nop", op_moved, 0);

        run_req("swap", OP_SWAP, 16'h0123, 4'd5, 1'b0, 2, 16'h2301, 1'b0);
        run_req("ext", OP_EXT, 16'h00FF, 4'd0, 1'b0, 2, 16'hFFFF, 1'b1);

        // Reset in the middle of a 10-step left shift
        begin
            bit saw_done;
            saw_done = 1'b0;
            @(negedge clk);
            operation = OP_LEFT_L; data_in = 16'h1234; count = 4'd10; fill = 1'b0; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                if (done) saw_done = 1'b1;
            end
            @(negedge clk);
            check_eq("abort_busy_before", busy, 1);
            rst = 1'b0;
            #1;
            check_eq("abort_ready", ready, 1);
            check_eq("abort_busy", busy, 0);
            check_eq("abort_result", result, 0);
            check_eq("abort_carry", carry, 0);
            check_eq("abort_sh_op", sh_operation, OP_NOP);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (done) saw_done = 1'b1;
            end
            rst = 1'b1;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (done) saw_done = 1'b1;
            end
            check_eq("abort_no_done", saw_done, 0);
        end

        run_req("post_rst", OP_LEFT_L, 16'h0001, 4'd2, 1'b1, 3, 16'h0007, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
